jtgng_romload_ctrl: RTL and testbench

//  Front end of ROM loading: takes the host download byte stream (packed ROM image, single clock domain)
//  and drives the romload_* write port of the ROM store. Remaps packed offsets into the sparse ROM-store map,

---
 rtl/jtgng_romload_ctrl_if.sv | 27 ++
 rtl/jtgng_romload_ctrl.sv | 137 +++++++++++++
 tb/tb_jtgng_romload_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtgng_romload_ctrl_if.sv
// Host download / ROM-store write bus for the ROM load front end.
//   ioctl_*   : host byte stream (download flag, slot index, strobe, packed
//               offset, data) and the throttle back to the host (ioctl_wait).
//   romload_* : write port into the sparse ROM store (strobe, address, data).
// The controller sits on the slave side: it consumes the ioctl stream and
// drives the ROM-store write port.
interface jtgng_romload_ctrl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        romload_wr;
  logic [18:0] romload_addr;
  logic [7:0]  romload_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, romload_wr, romload_addr, romload_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, romload_wr, romload_addr, romload_data
  );
endinterface

// File: rtl/jtgng_romload_ctrl.sv
// ROM loading front end. Takes the packed ROM image streamed by the host,
// remaps packed offsets into the sparse ROM-store map, stretches each write
// strobe to WR_LEN cycles while throttling the host, counts and checksums
// written bytes and holds the game in reset while loading.
// Ports:
//   clk, rst   : system clock (also the ROM-store write clock), sync reset
//   bus        : ioctl_* host stream in, ioctl_wait / romload_* out
//   rst_game   : game reset request, released one cycle after load completes
//   load_done  : image loaded, sticky until next download
//   load_err   : sticky overflow / strobe-while-busy flag
//   byte_cnt   : bytes written this download (saturating)
//   checksum   : mod-256 sum of written bytes
module jtgng_romload_ctrl #(
  parameter int unsigned WR_LEN    = 2,
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [21:0] OBJ1_PK   = 22'h38000,
  parameter logic [21:0] OBJ2_PK   = 22'h44000,
  parameter logic [21:0] ROM_END   = 22'h50000
) (
  input  logic                       clk,
  input  logic                       rst,
  jtgng_romload_ctrl_if.slave        bus,
  output logic                       rst_game,
  output logic                       load_done,
  output logic                       load_err,
  output logic [19:0]                byte_cnt,
  output logic [7:0]                 checksum
);

  localparam int unsigned CW = (WR_LEN > 1) ? $clog2(WR_LEN) : 1;
  localparam logic [18:0] OBJ1_19 = OBJ1_PK[18:0];
  localparam logic [18:0] OBJ2_19 = OBJ2_PK[18:0];

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t       state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [18:0]  addr_q, addr_nx;
  logic [7:0]   data_q, data_nx;
  logic         rst_game_nx, load_done_nx, load_err_nx;
  logic [19:0]  byte_cnt_nx;
  logic [7:0]   checksum_nx;
  logic         active, strobe, ovf;
  logic [18:0]  mapped;

  assign active = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign strobe = active && bus.ioctl_wr;
  assign ovf    = (|bus.ioctl_addr[21:19]) || (bus.ioctl_addr >= ROM_END);

  always_comb begin
    mapped = bus.ioctl_addr[18:0];
    if (bus.ioctl_addr >= OBJ2_PK)
      mapped = bus.ioctl_addr[18:0] - OBJ2_19 + 19'h50000;
    else if (bus.ioctl_addr >= OBJ1_PK)
      mapped = bus.ioctl_addr[18:0] - OBJ1_19 + 19'h40000;
  end

  always_comb begin
    state_nx     = state;
    wcnt_nx      = wcnt;
    addr_nx      = addr_q;
    data_nx      = data_q;
    rst_game_nx  = 1'b1;
    load_done_nx = load_done;
    load_err_nx  = load_err;
    byte_cnt_nx  = byte_cnt;
    checksum_nx  = checksum;
    case (state)
      IDLE, DONE: begin
        // rst_game is registered, so it drops one cycle after DONE entry
        if (state == DONE && !active) rst_game_nx = 1'b0;
        if (active) begin
          state_nx     = LOAD;
          byte_cnt_nx  = '0;
          checksum_nx  = '0;
          load_done_nx = 1'b0;
          load_err_nx  = 1'b0;
        end
      end
      LOAD: begin
        if (strobe) begin
          if (ovf) begin
            load_err_nx = 1'b1;
          end else begin
            addr_nx  = mapped;
            data_nx  = bus.ioctl_dout;
            wcnt_nx  = '0;
            state_nx = WRITE;
          end
        end else if (!active) begin
          state_nx     = DONE;
          load_done_nx = 1'b1;
        end
      end
      WRITE: begin
        if (strobe) load_err_nx = 1'b1;
        if (wcnt == '0) begin
          byte_cnt_nx = (&byte_cnt) ? byte_cnt : byte_cnt + 20'd1;
          checksum_nx = checksum + data_q;
        end
        if (wcnt == CW'(WR_LEN - 1)) state_nx = LOAD;
        else                         wcnt_nx  = wcnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rst_game  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      byte_cnt  <= '0;
      checksum  <= '0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      addr_q    <= addr_nx;
      data_q    <= data_nx;
      rst_game  <= rst_game_nx;
      load_done <= load_done_nx;
      load_err  <= load_err_nx;
      byte_cnt  <= byte_cnt_nx;
      checksum  <= checksum_nx;
    end
  end

  assign bus.romload_wr   = (state == WRITE);
  assign bus.ioctl_wait   = (state == WRITE);
  assign bus.romload_addr = addr_q;
  assign bus.romload_data = data_q;

endmodule

// File: tb/tb_jtgng_romload_ctrl.sv
module tb_jtgng_romload_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // DUT A: default parameters, directed tests
  jtgng_romload_ctrl_if bus_a();
  logic        rst_game_a, load_done_a, load_err_a;
  logic [19:0] byte_cnt_a;
  logic [7:0]  checksum_a;
  jtgng_romload_ctrl #(.WR_LEN(2), .ROM_INDEX(8'd0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .rst_game(rst_game_a), .load_done(load_done_a), .load_err(load_err_a),
    .byte_cnt(byte_cnt_a), .checksum(checksum_a));

  // DUT B: scaled-down image map so a complete random image fits the run
  localparam int unsigned B_WR  = 3;
  localparam int unsigned B_O1  = 'h0C00;
  localparam int unsigned B_O2  = 'h1000;
  localparam int unsigned B_END = 'h1800;
  jtgng_romload_ctrl_if bus_b();
  logic        rst_game_b, load_done_b, load_err_b;
  logic [19:0] byte_cnt_b;
  logic [7:0]  checksum_b;
  jtgng_romload_ctrl #(.WR_LEN(B_WR), .ROM_INDEX(8'd2), .OBJ1_PK(22'h0C00),
                       .OBJ2_PK(22'h1000), .ROM_END(22'h1800)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .rst_game(rst_game_b), .load_done(load_done_b), .load_err(load_err_b),
    .byte_cnt(byte_cnt_b), .checksum(checksum_b));

  function automatic logic [18:0] b_map(input int unsigned a);
    int unsigned r;
    if (a < B_O1)      r = a;
    else if (a < B_O2) r = a - B_O1 + 'h40000;
    else               r = a - B_O2 + 'h50000;
    return r[18:0];
  endfunction

  typedef struct { logic [18:0] a; logic [7:0] d; } wr_t;
  wr_t expq[$];
  wr_t cur;
  logic prev_wr = 1'b0;
  int   run = 0;

  // Scoreboard for DUT B: each write must match the next expected byte,
  // hold address/data steady and last exactly B_WR cycles.
  always @(negedge clk) begin
    wr_t w;
    if (bus_b.romload_wr) begin
      if (!prev_wr) begin
        check("b write expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          w = expq.pop_front();
          check("b addr", bus_b.romload_addr, w.a);
          check("b data", bus_b.romload_data, w.d);
          cur <= w;
        end
        run <= 1;
      end else begin
        check("b addr stable", bus_b.romload_addr, cur.a);
        check("b data stable", bus_b.romload_data, cur.d);
        run <= run + 1;
      end
    end else if (prev_wr) begin
      check("b write length", run, B_WR);
    end
    prev_wr <= bus_b.romload_wr;
  end

  // DUT A single-byte transaction (WR_LEN=2), ends on the first free cycle
  task automatic a_write(input string nm, input logic [21:0] addr, input logic [7:0] d,
                         input logic exp_wr, input logic [18:0] exp_addr);
    bus_a.ioctl_addr = addr;
    bus_a.ioctl_dout = d;
    bus_a.ioctl_wr   = 1'b1;
    @(negedge clk);
    bus_a.ioctl_wr = 1'b0;
    check({nm, " wr c1"}, bus_a.romload_wr, exp_wr);
    check({nm, " wait c1"}, bus_a.ioctl_wait, exp_wr);
    if (exp_wr) begin
      check({nm, " addr"}, bus_a.romload_addr, exp_addr);
      check({nm, " data"}, bus_a.romload_data, d);
    end
    @(negedge clk);
    check({nm, " wr c2"}, bus_a.romload_wr, exp_wr);
    @(negedge clk);
    check({nm, " wr c3"}, bus_a.romload_wr, 0);
    check({nm, " wait c3"}, bus_a.ioctl_wait, 0);
  endtask

  typedef struct { logic [21:0] addr; logic [7:0] data; logic ovf; logic [18:0] map; } vec_t;
  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sum_a;
    logic        err_exp;
    logic [19:0] cnt_a;
    logic [7:0]  sum_b, d;
    int          guard;

    vecs[0] = '{22'h38000, 8'h11, 1'b0, 19'h40000};
    vecs[1] = '{22'h43FFF, 8'h22, 1'b0, 19'h4BFFF};
    vecs[2] = '{22'h44000, 8'h33, 1'b0, 19'h50000};
    vecs[3] = '{22'h4FFFF, 8'h44, 1'b0, 19'h5BFFF};
    vecs[4] = '{22'h37FFF, 8'h55, 1'b0, 19'h37FFF};
    vecs[5] = '{22'h00000, 8'h66, 1'b0, 19'h00000};
    vecs[6] = '{22'h50000, 8'h77, 1'b1, 19'h00000};
    vecs[7] = '{22'h80000, 8'h88, 1'b1, 19'h00000};
    vecs[8] = '{22'h3FFFFF, 8'h99, 1'b1, 19'h00000};

    rst = 1'b1;
    bus_a.ioctl_download = 0; bus_a.ioctl_index = 0; bus_a.ioctl_wr = 0;
    bus_a.ioctl_addr = '0; bus_a.ioctl_dout = '0;
    bus_b.ioctl_download = 0; bus_b.ioctl_index = 0; bus_b.ioctl_wr = 0;
    bus_b.ioctl_addr = '0; bus_b.ioctl_dout = '0;

    // Reset / idle
    repeat (3) @(negedge clk);
    check("rst rst_game", rst_game_a, 1);
    check("rst romload_wr", bus_a.romload_wr, 0);
    check("rst wait", bus_a.ioctl_wait, 0);
    check("rst load_done", load_done_a, 0);
    check("rst load_err", load_err_a, 0);
    check("rst byte_cnt", byte_cnt_a, 0);
    check("rst checksum", checksum_a, 0);
    rst = 1'b0;

    // Single byte
    bus_a.ioctl_download = 1'b1;
    bus_a.ioctl_index    = 8'd0;
    @(negedge clk);
    check("load rst_game", rst_game_a, 1);
    a_write("byte A5", 22'h00010, 8'hA5, 1'b1, 19'h00010);
    check("byte A5 cnt", byte_cnt_a, 1);
    check("byte A5 sum", checksum_a, 8'hA5);

    // Remap and overflow table
    sum_a = 8'hA5; cnt_a = 1; err_exp = 1'b0;
    foreach (vecs[i]) begin
      a_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, !vecs[i].ovf, vecs[i].map);
      if (vecs[i].ovf) err_exp = 1'b1;
      else begin sum_a += vecs[i].data; cnt_a++; end
      check($sformatf("vec%0d err", i), load_err_a, err_exp);
    end
    check("table cnt", byte_cnt_a, cnt_a);
    check("table sum", checksum_a, sum_a);

    // Download end: done flag, delayed game reset release
    bus_a.ioctl_download = 1'b0;
    @(negedge clk);
    check("done flag", load_done_a, 1);
    check("done rst_game held", rst_game_a, 1);
    @(negedge clk);
    check("done rst_game released", rst_game_a, 0);
    check("done sticky", load_done_a, 1);
    bus_a.ioctl_download = 1'b1;
    @(negedge clk);
    check("restart done clr", load_done_a, 0);
    check("restart err clr", load_err_a, 0);
    check("restart cnt clr", byte_cnt_a, 0);
    check("restart rst_game", rst_game_a, 1);

    // Strobe while busy
    bus_a.ioctl_addr = 22'h123; bus_a.ioctl_dout = 8'h3C; bus_a.ioctl_wr = 1'b1;
    @(negedge clk);
    check("busy wr c1", bus_a.romload_wr, 1);
    bus_a.ioctl_addr = 22'h200; bus_a.ioctl_dout = 8'hFF;
    @(negedge clk);
    bus_a.ioctl_wr = 1'b0;
    check("busy wr c2", bus_a.romload_wr, 1);
    check("busy addr kept", bus_a.romload_addr, 19'h123);
    check("busy data kept", bus_a.romload_data, 8'h3C);
    check("busy err", load_err_a, 1);
    @(negedge clk);
    check("busy wr c3", bus_a.romload_wr, 0);
    check("busy cnt", byte_cnt_a, 1);
    check("busy sum", checksum_a, 8'h3C);
    @(negedge clk);
    check("busy no 2nd write", bus_a.romload_wr, 0);

    // Reset in the middle of a write
    bus_a.ioctl_addr = 22'h456; bus_a.ioctl_dout = 8'h5A; bus_a.ioctl_wr = 1'b1;
    @(negedge clk);
    bus_a.ioctl_wr = 1'b0;
    check("midrst wr before", bus_a.romload_wr, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst wr", bus_a.romload_wr, 0);
    check("midrst wait", bus_a.ioctl_wait, 0);
    check("midrst rst_game", rst_game_a, 1);
    check("midrst cnt", byte_cnt_a, 0);
    rst = 1'b0;
    bus_a.ioctl_index = 8'd1;
    for (int i = 0; i < 6; i++) begin
      bus_a.ioctl_wr = i[0];
      bus_a.ioctl_addr = 22'(i * 16);
      @(negedge clk);
      check($sformatf("idx1 wr %0d", i), bus_a.romload_wr, 0);
      check($sformatf("idx1 err %0d", i), load_err_a, 0);
      check($sformatf("idx1 cnt %0d", i), byte_cnt_a, 0);
    end
    bus_a.ioctl_wr = 1'b0;
    bus_a.ioctl_download = 1'b0;

    // Full random image into DUT B, download drops during the final write
    sum_b = '0;
    bus_b.ioctl_index = 8'd2;
    bus_b.ioctl_download = 1'b1;
    @(negedge clk);
    for (int unsigned a = 0; a < B_END; a++) begin
      guard = 0;
      while (bus_b.ioctl_wait && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        check("b wait bound", 0, 1);
        break;
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
      d = 8'($urandom);
      bus_b.ioctl_addr = 22'(a);
      bus_b.ioctl_dout = d;
      bus_b.ioctl_wr   = 1'b1;
      expq.push_back('{b_map(a), d});
      sum_b += d;
      @(negedge clk);
      bus_b.ioctl_wr = 1'b0;
      if (a == B_END - 1) bus_b.ioctl_download = 1'b0;
    end
    check("b final write in progress", bus_b.romload_wr, 1);
    guard = 0;
    while (!load_done_b && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("b done within bound", guard < 50, 1);
    check("b load_done", load_done_b, 1);
    check("b queue drained", expq.size(), 0);
    check("b byte_cnt", byte_cnt_b, B_END);
    check("b checksum", checksum_b, sum_b);
    check("b load_err", load_err_b, 0);
    repeat (2) @(negedge clk);
    check("b rst_game", rst_game_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
